// File: rtl/esp32_prog_sequencer.sv
// ---------------------------------------------------------------------------
// esp32_prog_sequencer
//   Decodes the esptool auto-reset pattern arriving on the FTDI modem-control
//   lines and drives the ESP32 EN / GPIO0 pins. A programming entry (EN high
//   with GPIO0 low) starts a fixed hold window. During that window GPIO0 and
//   the SD_D0 strap are held low. Programming entries are counted for status
//   display.
//
// Parameters
//   C_sync_stages           synchroniser depth for ndtr, nrts and btn_boot_n (>=2)
//   C_prog_release_timeout  hold window is 2**C cycles
//
// Ports
//   clk_25MHz    in   main clock
//   rst_n        in   asynchronous reset, active-low
//   ftdi_ndtr    in   FTDI DTR#, asynchronous
//   ftdi_nrts    in   FTDI RTS#, asynchronous
//   btn_boot_n   in   boot button, asynchronous; 0 forces GPIO0 low in RUN
//   wifi_en      out  ESP32 EN, registered
//   wifi_gpio0   out  ESP32 GPIO0 strap, registered
//   strap_drive  out  1 = top drives sd_d[0] with strap_value
//   strap_value  out  level for sd_d[0] while strap_drive=1
//   prog_active  out  1 while the hold window is running
//   prog_count   out  programming entries, saturating at 255
// ---------------------------------------------------------------------------
module esp32_prog_sequencer #(
  parameter int C_sync_stages          = 2,
  parameter int C_prog_release_timeout = 17
) (
  input  logic       clk_25MHz,
  input  logic       rst_n,
  input  logic       ftdi_ndtr,
  input  logic       ftdi_nrts,
  input  logic       btn_boot_n,
  output logic       wifi_en,
  output logic       wifi_gpio0,
  output logic       strap_drive,
  output logic       strap_value,
  output logic       prog_active,
  output logic [7:0] prog_count
);

  localparam int CW = C_prog_release_timeout + 1;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  // Synchroniser: bit 2 = ndtr, bit 1 = nrts, bit 0 = boot button.
  // Every stage resets to 1, which matches the idle level of all three lines.
  logic [C_sync_stages-1:0][2:0] sync_reg;
  logic dtr_s, rts_s, btn_s;

  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '1;
    end else begin
      sync_reg <= {sync_reg[C_sync_stages-2:0], {ftdi_ndtr, ftdi_nrts, btn_boot_n}};
    end
  end

  assign dtr_s = sync_reg[C_sync_stages-1][2];
  assign rts_s = sync_reg[C_sync_stages-1][1];
  assign btn_s = sync_reg[C_sync_stages-1][0];

  // Decode the synchronised pair into {en_d, io0_d}. The cross-wiring means
  // that only one of EN or GPIO0 can be pulled low at any time.
  logic [1:0] dec;
  logic       en_d, io0_d;

  always_comb begin
    case ({dtr_s, rts_s})
      2'b10:   dec = 2'b01;
      2'b01:   dec = 2'b10;
      default: dec = 2'b11;
    endcase
  end

  assign en_d  = dec[1];
  assign io0_d = dec[0];

  logic [1:0]    prev_dec_reg;
  logic [0:0]    state_reg, state_next;
  logic [CW-1:0] counter_reg, counter_next, counter_inc;
  logic [7:0]    count_next;
  logic          trigger;

  // Edge-detect entry into EN=1/GPIO0=0 so a held pattern counts only once.
  assign trigger     = (dec == 2'b10) && (prev_dec_reg != 2'b10);
  assign counter_inc = counter_reg + 1'b1;

  // Next-state logic. The output registers follow state_next, so
  // prog_active is high for exactly the cycles spent in HOLD. HOLD is left
  // on the edge where the incremented counter reaches its MSB. That edge
  // falls 2**C cycles after entry.
  always_comb begin
    state_next   = state_reg;
    counter_next = counter_reg;
    count_next   = prog_count;
    case (state_reg)
      ST_RUN: begin
        if (trigger) begin
          state_next   = ST_HOLD;
          counter_next = '0;
          count_next   = (prog_count == 8'hFF) ? prog_count : prog_count + 8'd1;
        end
      end
      default: begin
        if (dec == 2'b01) begin
          // EN pulled low: abort. This beats the timeout.
          state_next   = ST_RUN;
          counter_next = '0;
        end else if (trigger) begin
          // Retrigger: reload the window. This also beats the timeout.
          counter_next = '0;
          count_next   = (prog_count == 8'hFF) ? prog_count : prog_count + 8'd1;
        end else begin
          counter_next = counter_inc;
          if (counter_inc[CW-1]) begin
            state_next = ST_RUN;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      prev_dec_reg <= 2'b11;
      state_reg    <= ST_RUN;
      counter_reg  <= '0;
      prog_count   <= 8'd0;
      wifi_en      <= 1'b1;
      wifi_gpio0   <= 1'b1;
      strap_drive  <= 1'b0;
      strap_value  <= 1'b1;
      prog_active  <= 1'b0;
    end else begin
      prev_dec_reg <= dec;
      state_reg    <= state_next;
      counter_reg  <= counter_next;
      prog_count   <= count_next;
      wifi_en      <= en_d;
      if (state_next == ST_HOLD) begin
        wifi_gpio0  <= 1'b0;
        strap_drive <= 1'b1;
        strap_value <= 1'b0;
        prog_active <= 1'b1;
      end else begin
        wifi_gpio0  <= io0_d & btn_s;
        strap_drive <= 1'b0;
        prog_active <= 1'b0;
      end
    end
  end

endmodule
